// File: rtl/mpb_arb.sv
// mpb_arb: NM-master single-port SRAM arbiter (fixed/round-robin + starvation guard)
// Ports: m_* per-master req/grant/read-valid, ram_* SRAM macro, bist_* override, blk global block
module mpb_arb #(
  parameter int NM       = 3,
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int RR_EN    = 0,
  parameter int MAX_WAIT = 7
) (
  input  logic             mclk,
  input  logic             srst,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdat,
  output logic [NM-1:0]    m_gnt,
  output logic [NM-1:0]    m_rvld,
  output logic [DW-1:0]    rdat,
  input  logic             blk,
  output logic             ram_ce,
  output logic             ram_we,
  output logic [AW-1:0]    ram_a,
  output logic [DW-1:0]    ram_d,
  input  logic [DW-1:0]    ram_q,
  input  logic             bist_en,
  input  logic             bist_wr,
  input  logic [AW-1:0]    bist_adr,
  input  logic [DW-1:0]    bist_wdat
);

  localparam logic [3:0]    LP_MAXW = 4'(MAX_WAIT);
  localparam logic [NM-1:0] LP_ONE  = NM'(1);

  logic [3:0]        r_wait [NM];
  logic [2:0]        r_rr_ptr;
  logic [RD_LAT-1:0] r_pv;
  logic [2:0]        r_pid [RD_LAT];

  logic [NM-1:0] w_starv;
  logic [NM-1:0] w_mask;
  logic [NM-1:0] w_hi;
  logic [NM-1:0] w_sel;
  logic [NM-1:0] w_gnt;
  logic [2:0]    w_gid;
  logic          w_en;
  logic          w_rd;
  logic          w_we_g;
  logic          w_v;
  logic [AW-1:0] w_a_g;
  logic [DW-1:0] w_d_g;

  // isolate the lowest set bit
  function automatic logic [NM-1:0] f_low(input logic [NM-1:0] v);
    return v & (~v + LP_ONE);
  endfunction

  // w_mask marks masters at or above rr_ptr; searching those first
  // and falling back to the full set gives the upward search with wrap
  always_comb begin
    w_starv = '0;
    w_mask  = '0;
    for (int i = 0; i < NM; i++) begin
      w_starv[i] = m_req[i] & (r_wait[i] >= LP_MAXW);
      w_mask[i]  = (3'(i) >= r_rr_ptr);
    end
    w_hi = m_req & w_mask;
    if (|w_starv)
      w_sel = f_low(w_starv);
    else if (RR_EN == 0)
      w_sel = f_low(m_req);
    else if (|w_hi)
      w_sel = f_low(w_hi);
    else
      w_sel = f_low(m_req);
  end

  assign w_en  = ~(blk | bist_en | srst);
  assign w_gnt = w_en ? w_sel : '0;
  assign m_gnt = w_gnt;

  always_comb begin
    w_gid  = '0;
    w_we_g = 1'b0;
    w_a_g  = '0;
    w_d_g  = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_gnt[i]) begin
        w_gid  = 3'(i);
        w_we_g = m_we[i];
        w_a_g  = m_addr[i*AW +: AW];
        w_d_g  = m_wdat[i*DW +: DW];
      end
    end
  end

  assign w_rd = |(w_gnt & ~m_we);

  assign ram_ce = ~srst & (bist_en | (|w_gnt));
  assign ram_we = ~srst & (bist_en ? bist_wr : w_we_g);
  assign ram_a  = bist_en ? bist_adr  : w_a_g;
  assign ram_d  = bist_en ? bist_wdat : w_d_g;

  always_ff @(posedge mclk or posedge srst) begin
    if (srst)
      r_rr_ptr <= '0;
    else if ((RR_EN != 0) && (|w_gnt))
      r_rr_ptr <= (w_gid == 3'(NM-1)) ? 3'd0 : w_gid + 3'd1;
  end

  always_ff @(posedge mclk or posedge srst) begin
    if (srst) begin
      for (int i = 0; i < NM; i++)
        r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (w_gnt[i] | ~m_req[i])
          r_wait[i] <= '0;
        else if (r_wait[i] != 4'hF)
          r_wait[i] <= r_wait[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge mclk or posedge srst) begin
    if (srst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++)
        r_pid[i] <= '0;
    end else begin
      r_pv[0]  <= w_rd;
      r_pid[0] <= w_gid;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign w_v = r_pv[RD_LAT-1] & ~srst;

  always_comb begin
    m_rvld = '0;
    for (int i = 0; i < NM; i++)
      m_rvld[i] = w_v & (r_pid[RD_LAT-1] == 3'(i));
  end

  assign rdat = w_v ? ram_q : '0;

endmodule

// File: tb/tb_mpb_arb.sv
// tb_mpb_arb: directed checks of mpb_arb, fixed-priority/RD_LAT=1 and
// round-robin/RD_LAT=2 instances sharing stimulus, each with an SRAM model
module tb_mpb_arb;

  logic        mclk = 1'b0;
  logic        srst;
  logic [2:0]  m_req, m_we;
  logic [32:0] m_addr;
  logic [23:0] m_wdat;
  logic        blk, bist_en, bist_wr;
  logic [10:0] bist_adr;
  logic [7:0]  bist_wdat;

  logic [2:0]  gnt_f, rvld_f, gnt_r, rvld_r;
  logic [7:0]  rdat_f, rdat_r, d_f, d_r, q_f, q_r;
  logic        ce_f, we_f, ce_r, we_r;
  logic [10:0] a_f, a_r;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 mclk = ~mclk;

  mpb_arb #(.NM(3), .AW(11), .DW(8), .RD_LAT(1), .RR_EN(0), .MAX_WAIT(7)) u_fp (
    .mclk(mclk), .srst(srst), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdat(m_wdat), .m_gnt(gnt_f), .m_rvld(rvld_f),
    .rdat(rdat_f), .blk(blk), .ram_ce(ce_f), .ram_we(we_f),
    .ram_a(a_f), .ram_d(d_f), .ram_q(q_f), .bist_en(bist_en),
    .bist_wr(bist_wr), .bist_adr(bist_adr), .bist_wdat(bist_wdat)
  );

  mpb_arb #(.NM(3), .AW(11), .DW(8), .RD_LAT(2), .RR_EN(1), .MAX_WAIT(7)) u_rr (
    .mclk(mclk), .srst(srst), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdat(m_wdat), .m_gnt(gnt_r), .m_rvld(rvld_r),
    .rdat(rdat_r), .blk(blk), .ram_ce(ce_r), .ram_we(we_r),
    .ram_a(a_r), .ram_d(d_r), .ram_q(q_r), .bist_en(bist_en),
    .bist_wr(bist_wr), .bist_adr(bist_adr), .bist_wdat(bist_wdat)
  );

  logic [7:0] mem_f [2048];
  logic [7:0] mem_r [2048];
  logic [7:0] qr1;

  always @(posedge mclk) begin
    if (ce_f && we_f) mem_f[a_f] <= d_f;
    if (ce_f && !we_f) q_f <= mem_f[a_f];
  end

  always @(posedge mclk) begin
    if (ce_r && we_r) mem_r[a_r] <= d_r;
    if (ce_r && !we_r) qr1 <= mem_r[a_r];
    q_r <= qr1;
  end

  task automatic pulse_rst;
    @(negedge mclk);
    srst = 1'b1;
    m_req = '0;
    @(negedge mclk);
    srst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge mclk);
    m_req = 3'b111;
    #1;
    n_tot++; if ({gnt_f, gnt_r} !== 6'b0) $display("FAIL rst_gnt: got %b want 0", {gnt_f, gnt_r}); else n_pass++;
    n_tot++; if ({ce_f, we_f, ce_r, we_r} !== 4'b0) $display("FAIL rst_ram: got %b want 0", {ce_f, we_f, ce_r, we_r}); else n_pass++;
    n_tot++; if ({rvld_f, rvld_r, rdat_f, rdat_r} !== 22'b0) $display("FAIL rst_rd: got %h want 0", {rvld_f, rvld_r, rdat_f, rdat_r}); else n_pass++;
    n_tot++; if (u_rr.r_rr_ptr !== 3'd0) $display("FAIL rst_ptr: got %0d want 0", u_rr.r_rr_ptr); else n_pass++;
    @(negedge mclk);
    srst = 1'b0;
    m_req = '0;
  endtask

  task automatic test_fixed_priority;
    logic [2:0] exp;
    pulse_rst();
    for (int c = 0; c < 10; c++) begin
      @(negedge mclk);
      m_req = 3'b111;
      m_we = '0;
      #1;
      exp = (c < 7) ? 3'b001 : (c == 7) ? 3'b010 : (c == 8) ? 3'b100 : 3'b001;
      n_tot++; if (gnt_f !== exp) $display("FAIL fp_gnt c%0d: got %b want %b", c, gnt_f, exp); else n_pass++;
    end
    @(negedge mclk);
    m_req = '0;
  endtask

  task automatic test_round_robin;
    logic [2:0] eg, ep;
    pulse_rst();
    for (int c = 0; c < 4; c++) begin
      @(negedge mclk);
      m_req = 3'b111;
      m_we = '0;
      #1;
      eg = (c == 1) ? 3'b010 : (c == 2) ? 3'b100 : 3'b001;
      ep = (c == 1) ? 3'd2 : (c == 2) ? 3'd0 : 3'd1;
      n_tot++; if (gnt_r !== eg) $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt_r, eg); else n_pass++;
      @(posedge mclk);
      #1;
      n_tot++; if (u_rr.r_rr_ptr !== ep) $display("FAIL rr_ptr c%0d: got %0d want %0d", c, u_rr.r_rr_ptr, ep); else n_pass++;
    end
    @(negedge mclk);
    m_req = '0;
  endtask

  task automatic test_read_latency;
    @(negedge mclk);
    bist_en = 1'b1; bist_wr = 1'b1;
    bist_adr = 11'h123; bist_wdat = 8'h5A;
    m_req = '0;
    @(negedge mclk);
    bist_en = 1'b0; bist_wr = 1'b0;
    m_req = 3'b100; m_we = '0;
    m_addr[22 +: 11] = 11'h123;
    #1;
    n_tot++; if (gnt_r !== 3'b100) $display("FAIL lat_gnt: got %b want 100", gnt_r); else n_pass++;
    n_tot++; if ({ce_r, we_r, a_r} !== {1'b1, 1'b0, 11'h123}) $display("FAIL lat_ram: got %h want %h", {ce_r, we_r, a_r}, {1'b1, 1'b0, 11'h123}); else n_pass++;
    @(negedge mclk);
    m_req = '0;
    #1;
    n_tot++; if (rvld_r !== 3'b000) $display("FAIL lat_rvld_t1: got %b want 000", rvld_r); else n_pass++;
    n_tot++; if ({rvld_f, rdat_f} !== {3'b100, 8'h5A}) $display("FAIL lat1_rd: got %h want %h", {rvld_f, rdat_f}, {3'b100, 8'h5A}); else n_pass++;
    @(negedge mclk);
    #1;
    n_tot++; if ({rvld_r, rdat_r} !== {3'b100, 8'h5A}) $display("FAIL lat_rd_t2: got %h want %h", {rvld_r, rdat_r}, {3'b100, 8'h5A}); else n_pass++;
    n_tot++; if (rvld_f !== 3'b000) $display("FAIL lat1_rvld_t2: got %b want 000", rvld_f); else n_pass++;
    @(negedge mclk);
    #1;
    n_tot++; if ({rvld_r, rdat_r} !== 11'b0) $display("FAIL lat_rd_t3: got %h want 0", {rvld_r, rdat_r}); else n_pass++;
  endtask

  task automatic test_block;
    for (int c = 0; c < 20; c++) begin
      @(negedge mclk);
      blk = 1'b1;
      m_req = 3'b010;
      #1;
      n_tot++; if ({gnt_f, ce_f, gnt_r, ce_r} !== 8'b0) $display("FAIL blk c%0d: got %b want 0", c, {gnt_f, ce_f, gnt_r, ce_r}); else n_pass++;
    end
    @(posedge mclk);
    #1;
    n_tot++; if (u_fp.r_wait[1] !== 4'd15) $display("FAIL blk_wait: got %0d want 15", u_fp.r_wait[1]); else n_pass++;
    @(negedge mclk);
    blk = 1'b0;
    #1;
    n_tot++; if ({gnt_f, gnt_r} !== 6'b010010) $display("FAIL blk_rel: got %b want 010010", {gnt_f, gnt_r}); else n_pass++;
    @(negedge mclk);
    m_req = '0;
  endtask

  task automatic test_write_read;
    @(negedge mclk);
    m_req = 3'b001; m_we = 3'b001;
    m_addr[0 +: 11] = 11'h7FF;
    m_wdat[0 +: 8] = 8'hC3;
    #1;
    n_tot++; if (gnt_f !== 3'b001) $display("FAIL wr_gnt: got %b want 001", gnt_f); else n_pass++;
    n_tot++; if ({ce_f, we_f, a_f, d_f} !== {2'b11, 11'h7FF, 8'hC3}) $display("FAIL wr_ram: got %h want %h", {ce_f, we_f, a_f, d_f}, {2'b11, 11'h7FF, 8'hC3}); else n_pass++;
    @(negedge mclk);
    m_req = 3'b010; m_we = '0;
    m_addr[11 +: 11] = 11'h7FF;
    #1;
    n_tot++; if ({gnt_f, rvld_f, rvld_r} !== 9'b010_000_000) $display("FAIL rd_gnt: got %b want 010000000", {gnt_f, rvld_f, rvld_r}); else n_pass++;
    @(negedge mclk);
    m_req = '0;
    #1;
    n_tot++; if ({rvld_f, rdat_f} !== {3'b010, 8'hC3}) $display("FAIL wrrd_f: got %h want %h", {rvld_f, rdat_f}, {3'b010, 8'hC3}); else n_pass++;
    n_tot++; if (rvld_r !== 3'b000) $display("FAIL wrrd_r_early: got %b want 000", rvld_r); else n_pass++;
    @(negedge mclk);
    #1;
    n_tot++; if ({rvld_r, rdat_r} !== {3'b010, 8'hC3}) $display("FAIL wrrd_r: got %h want %h", {rvld_r, rdat_r}, {3'b010, 8'hC3}); else n_pass++;
  endtask

  task automatic test_bist;
    @(negedge mclk);
    bist_en = 1'b1; bist_wr = 1'b1;
    bist_adr = 11'h010; bist_wdat = 8'hFF;
    m_req = 3'b001; m_we = '0;
    #1;
    n_tot++; if ({ce_f, we_f, a_f, d_f} !== {2'b11, 11'h010, 8'hFF}) $display("FAIL bist_ram: got %h want %h", {ce_f, we_f, a_f, d_f}, {2'b11, 11'h010, 8'hFF}); else n_pass++;
    n_tot++; if ({gnt_f, gnt_r} !== 6'b0) $display("FAIL bist_gnt: got %b want 0", {gnt_f, gnt_r}); else n_pass++;
    @(negedge mclk);
    blk = 1'b1; bist_wr = 1'b0;
    #1;
    n_tot++; if ({ce_r, we_r, a_r, gnt_r} !== {2'b10, 11'h010, 3'b000}) $display("FAIL bist_blk: got %h want %h", {ce_r, we_r, a_r, gnt_r}, {2'b10, 11'h010, 3'b000}); else n_pass++;
    @(negedge mclk);
    bist_en = 1'b0; blk = 1'b0;
    #1;
    n_tot++; if ({gnt_f, a_f} !== {3'b001, 11'h7FF}) $display("FAIL bist_off: got %h want %h", {gnt_f, a_f}, {3'b001, 11'h7FF}); else n_pass++;
    @(negedge mclk);
    m_req = '0;
  endtask

  task automatic test_reset_midread;
    pulse_rst();
    @(negedge mclk);
    m_req = 3'b010; m_we = '0;
    #1;
    n_tot++; if (gnt_r !== 3'b010) $display("FAIL mr_gnt: got %b want 010", gnt_r); else n_pass++;
    @(negedge mclk);
    m_req = '0;
    #1;
    n_tot++; if (rvld_f !== 3'b010) $display("FAIL mr_rvld_f: got %b want 010", rvld_f); else n_pass++;
    n_tot++; if (u_rr.r_rr_ptr !== 3'd2) $display("FAIL mr_ptr_pre: got %0d want 2", u_rr.r_rr_ptr); else n_pass++;
    srst = 1'b1;
    m_req = 3'b001;
    #1;
    n_tot++; if ({gnt_f, gnt_r, ce_f, ce_r, rvld_f, rvld_r, rdat_f} !== 22'b0) $display("FAIL mr_out: got %h want 0", {gnt_f, gnt_r, ce_f, ce_r, rvld_f, rvld_r, rdat_f}); else n_pass++;
    n_tot++; if (u_rr.r_rr_ptr !== 3'd0) $display("FAIL mr_ptr: got %0d want 0", u_rr.r_rr_ptr); else n_pass++;
    @(negedge mclk);
    srst = 1'b0;
    m_req = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tot++; if ({rvld_f, rvld_r} !== 6'b0) $display("FAIL mr_lost c%0d: got %b want 0", c, {rvld_f, rvld_r}); else n_pass++;
      @(negedge mclk);
    end
  endtask

  initial begin
    srst = 1'b1;
    m_req = '0; m_we = '0;
    m_addr = '0; m_wdat = '0;
    blk = 1'b0; bist_en = 1'b0; bist_wr = 1'b0;
    bist_adr = '0; bist_wdat = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_read_latency();
    test_block();
    test_write_read();
    test_bist();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mpb_arb.md
Name: mpb_arb

Overview:
Parametrised single-port SRAM arbiter for the memory peripheral bus. It generalises the fixed PG0/DMA/MCU XDAT mux to NM masters, with selectable fixed-priority or round-robin arbitration and a starvation guard. It also supports configurable SRAM read latency, so each master sees a tagged read-valid pulse. It sits between the bus masters (ESFRM PG0 port, DMA, MCU XDAT, future channels) and one SRAM macro, with BIST override and a global block input for a shared-SRAM IDAT owner.

Parameters:
NM, 3, number of masters (2..8); index 0 is highest fixed priority
AW, 11, SRAM address width
DW, 8, data width
RD_LAT, 1, SRAM read latency in cycles (1..3)
RR_EN, 0, 0 = fixed priority, 1 = round-robin
MAX_WAIT, 7, cycles a requesting master may wait before forced priority (1..15)

Ports:
mclk  in  1  clock
srst  in  1  asynchronous reset, active high
m_req  in  NM  per-master access request, held until m_gnt
m_we  in  NM  1 = write, 0 = read (valid with m_req)
m_addr  in  NM*AW  per-master address, master i at [i*AW +: AW]
m_wdat  in  NM*DW  per-master write data, same packing
m_gnt  out  NM  one-hot grant; write completes this cycle, read accepted this cycle
m_rvld  out  NM  read-data valid pulse to the originating master
rdat  out  DW  read data, valid while any m_rvld is high
blk  in  1  block all grants (e.g. IDAT owner using the same SRAM)
ram_ce  out  1  SRAM chip enable
ram_we  out  1  SRAM write enable
ram_a  out  AW  SRAM address
ram_d  out  DW  SRAM write data
ram_q  in  DW  SRAM read data
bist_en  in  1  BIST owns SRAM
bist_wr  in  1  BIST write
bist_adr  in  AW  BIST address
bist_wdat  in  DW  BIST write data

Behaviour:
- Reset (srst high, async): rr_ptr=0; all wait counters=0; read pipeline cleared. While srst is high, m_gnt=0, m_rvld=0, ram_ce=0, ram_we=0, rdat=0.
- Grant is combinational, the same cycle as the request. At most one m_gnt bit is high. m_gnt=0 when blk=1 or bist_en=1.
- Eligible set = m_req. Starved set = eligible masters with wait_cnt[i] >= MAX_WAIT.
  - If the starved set is non-empty, grant the lowest-index starved master.
  - Else if RR_EN=0, grant the lowest-index eligible master.
  - Else (RR_EN=1), grant the first eligible master at or after rr_ptr, searching upward with wrap NM-1 -> 0.
- rr_ptr (RR_EN=1 only): on any grant to master g, rr_ptr <= (g==NM-1) ? 0 : g+1. It holds when there is no grant.
- wait_cnt[i] (4 bit, saturating at 15):
  - cleared when m_gnt[i] or ~m_req[i];
  - otherwise +1 per cycle, including cycles blocked by blk or bist_en.
- SRAM drive:
  - bist_en=1: ram_ce=1, ram_we=bist_wr, ram_a=bist_adr, ram_d=bist_wdat.
  - Else: ram_ce=|m_gnt, ram_we=m_we of the granted master, ram_a/ram_d = that master's slices.
  - Else with no grant: ram_ce=0, ram_we=0, ram_a/ram_d=0.
- Read pipeline: a shift register RD_LAT deep of {valid, id[2:0]}, loaded on a read grant (m_gnt[g] & ~m_we[g]).
  - m_rvld[id] pulses for exactly 1 cycle, RD_LAT cycles after the grant cycle.
  - rdat = ram_q while valid, else 0.
  - Back-to-back reads produce back-to-back m_rvld, one per cycle, in order.
- Write: data is written on the grant cycle. No m_rvld.
- A master must not deassert m_req before m_gnt. Changing m_addr, m_we or m_wdat before grant is allowed; the values in the grant cycle are used.
- bist_en asserting while a read is in flight: the pipeline keeps shifting and m_rvld is still delivered (data is whatever ram_q holds). Masters must not rely on that data. Firmware never enables BIST during traffic.
- blk and bist_en both high: bist_en wins the SRAM ports, and there are no grants.
- srst asserting mid-read: the in-flight m_rvld is lost and the master must re-request.

Test Plan:
1. Fixed priority (RR_EN=0, NM=3): m_req=3'b111, all reads -> m_gnt 001,001,... while req0 is held. After 7 cycles waiting, master 1 is forced: at cycle 8, m_gnt=010.
2. Round-robin (RR_EN=1): m_req=3'b111 held, each master re-requests after grant -> m_gnt sequence 001,010,100,001; rr_ptr 1,2,0,1.
3. Read latency RD_LAT=2: master 2 reads addr 0x123 at cycle t with SRAM preloaded 0x5A -> ram_a=0x123 and ram_we=0 at t; m_rvld=3'b100 and rdat=0x5A at t+2 only.
4. Block: blk=1 for 20 cycles with req1=1 -> m_gnt=0 and ram_ce=0 throughout; wait_cnt1 saturates at 15; first cycle after blk=0 -> m_gnt=010.
5. Write then read, same address 0x7FF, data 0xC3 (master 0 write, master 1 read next cycle) -> m_rvld[1] with rdat=0xC3.
6. BIST override: bist_en=1, bist_wr=1, bist_adr=0x010, bist_wdat=0xFF with req0=1 -> ram_ce=1, ram_we=1, ram_a=0x010, m_gnt=0. srst pulse mid-sequence -> all outputs 0 immediately and rr_ptr=0.
